// File: rtl/if_pc_redirect_if.sv
// Instruction-memory fetch bus between the PC controller and the instruction store.
// The PC controller drives the address. The memory answers combinationally in the same cycle.
interface if_pc_redirect_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_pc_redirect.sv
// Fetch-stage PC controller with IF/ID pipeline register.
// It redirects fetch on a taken EX-stage control transfer and squashes the
// wrong-path IF and ID slots (2-bubble penalty).
module if_pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cond_stage,
    input  logic [31:0]             HAZ_OUT,
    input  logic                    stall,
    if_pc_redirect_if.master        imem,
    output logic [31:0]             IF_ID_IR,
    output logic [31:0]             IF_ID_PC,
    output logic [31:0]             IF_ID_NPC,
    output logic                    IF_ID_valid,
    output logic                    flush_id_ex,
    output logic                    misalign_err,
    output logic [15:0]             taken_cnt
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_npc_q, id_npc_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [15:0] taken_q, taken_d;

    // Next-state and next-register values, evaluated in per-edge priority order.
    always_comb begin
        // NOTE: every signal gets a hold value first, so no path through the
        // priority chain leaves one unassigned. This prevents latch inference.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        id_pc_d    = id_pc_q;
        id_npc_d   = id_npc_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        taken_d    = taken_q;

        unique case (state_q)
            BOOT:     state_d = RUN;
            RUN:      state_d = cond_stage ? REDIRECT : RUN;
            REDIRECT: state_d = cond_stage ? REDIRECT : RUN;
            default:  state_d = BOOT;
        endcase

        if (cond_stage) begin
            // The redirect beats a stall: the stalled instruction is wrong-path anyway.
            pc_d    = {HAZ_OUT[31:1], 1'b0};
            ir_d    = NOP_IR;
            valid_d = 1'b0;
            if (HAZ_OUT[1]) begin
                misalign_d = 1'b1;
            end
            if (taken_q != 16'hFFFF) begin
                taken_d = taken_q + 16'd1;
            end
        end else if (stall) begin
            // Load-use hold: PC and IF/ID keep their values.
        end else if (state_q == BOOT) begin
            // First cycle after reset: PC is presented, IF/ID keeps the bubble.
        end else begin
            ir_d     = imem.imem_rdata;
            id_pc_d  = pc_q;
            id_npc_d = pc_q + 32'd4;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples the pre-edge values and the update order does not matter.
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_IR;
            id_pc_q    <= 32'd0;
            id_npc_q   <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            taken_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            id_pc_q    <= id_pc_d;
            id_npc_q   <= id_npc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            taken_q    <= taken_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign IF_ID_IR       = ir_q;
    assign IF_ID_PC       = id_pc_q;
    assign IF_ID_NPC      = id_npc_q;
    assign IF_ID_valid    = valid_q;
    assign misalign_err   = misalign_q;
    assign taken_cnt      = taken_q;
    assign flush_id_ex    = rst_n & cond_stage;

endmodule

// File: tb/tb_if_pc_redirect.sv
// Directed bench for if_pc_redirect. It covers boot, sequential fetch, redirect,
// stall, misalignment, back-to-back redirects, PC wrap, reset mid-redirect, and
// counter saturation.
module tb_if_pc_redirect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cond_stage;
    logic [31:0] HAZ_OUT;
    logic        stall;
    logic [31:0] IF_ID_IR, IF_ID_PC, IF_ID_NPC;
    logic        IF_ID_valid, flush_id_ex, misalign_err;
    logic [15:0] taken_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_pc_redirect_if imem_bus ();

    if_pc_redirect dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cond_stage   (cond_stage),
        .HAZ_OUT      (HAZ_OUT),
        .stall        (stall),
        .imem         (imem_bus),
        .IF_ID_IR     (IF_ID_IR),
        .IF_ID_PC     (IF_ID_PC),
        .IF_ID_NPC    (IF_ID_NPC),
        .IF_ID_valid  (IF_ID_valid),
        .flush_id_ex  (flush_id_ex),
        .misalign_err (misalign_err),
        .taken_cnt    (taken_cnt)
    );

    always #5 clk = ~clk;

    // Instruction store: address 0 holds addi x1,x0,5; every other word is tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'd0) ? 32'h0050_0093 : (32'hA500_0000 | a);
    endfunction

    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cond_stage = 1'b0; HAZ_OUT = 32'd0; stall = 1'b0;
        step();
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0200;
        step();
        #1;
        check("rst_flush", {31'd0, flush_id_ex}, 32'd0);
        check("rst_pc", imem_bus.imem_addr, 32'd0);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rst_ir", IF_ID_IR, 32'h0000_0013);
        check("rst_taken", {16'd0, taken_cnt}, 32'd0);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Release before edge 0: edge 0 is the BOOT cycle.
        rst_n = 1'b1; cond_stage = 1'b0; HAZ_OUT = 32'd0;
        #1;
        check("boot_valid", {31'd0, IF_ID_valid}, 32'd0);
        step(); // edge 0
        check("boot_hold_pc", imem_bus.imem_addr, 32'd0);
        check("boot_hold_valid", {31'd0, IF_ID_valid}, 32'd0);
        step(); // edge 1
        check("e1_ir", IF_ID_IR, 32'h0050_0093);
        check("e1_pc", IF_ID_PC, 32'd0);
        check("e1_npc", IF_ID_NPC, 32'd4);
        check("e1_valid", {31'd0, IF_ID_valid}, 32'd1);
        step(); // edge 2
        check("e2_addr", imem_bus.imem_addr, 32'd8);
        check("e2_pc", IF_ID_PC, 32'd4);
        check("e2_ir", IF_ID_IR, 32'hA500_0004);
        step();
        check("e3_pc", IF_ID_PC, 32'd8);
        step();
        check("e4_pc", IF_ID_PC, 32'd12);
        check("e4_valid", {31'd0, IF_ID_valid}, 32'd1);
        check("e4_taken", {16'd0, taken_cnt}, 32'd0);
        check("e4_addr", imem_bus.imem_addr, 32'h10);

        // Redirect to 0x100 while PC = 0x10.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0100;
        #1;
        check("br_flush", {31'd0, flush_id_ex}, 32'd1);
        step();
        cond_stage = 1'b0;
        check("br_addr", imem_bus.imem_addr, 32'h100);
        check("br_valid0", {31'd0, IF_ID_valid}, 32'd0);
        check("br_pc_hold", IF_ID_PC, 32'd12);
        check("br_ir_nop", IF_ID_IR, 32'h0000_0013);
        step();
        check("br_tgt_pc", IF_ID_PC, 32'h100);
        check("br_tgt_ir", IF_ID_IR, 32'hA500_0100);
        check("br_valid1", {31'd0, IF_ID_valid}, 32'd1);
        check("br_taken", {16'd0, taken_cnt}, 32'd1);

        // Redirect to 0x1C, then fetch once so that PC = 0x20 with a valid IF/ID.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_001C;
        step();
        cond_stage = 1'b0;
        step();
        check("pre_stall_addr", imem_bus.imem_addr, 32'h20);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", imem_bus.imem_addr, 32'h20);
            check("stall_pc", IF_ID_PC, 32'h1C);
            check("stall_npc", IF_ID_NPC, 32'h20);
            check("stall_ir", IF_ID_IR, 32'hA500_001C);
            check("stall_valid", {31'd0, IF_ID_valid}, 32'd1);
        end
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0040;
        #1;
        check("stbr_flush", {31'd0, flush_id_ex}, 32'd1);
        step();
        cond_stage = 1'b0; stall = 1'b0;
        check("stbr_addr", imem_bus.imem_addr, 32'h40);
        check("stbr_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("stbr_taken", {16'd0, taken_cnt}, 32'd3);

        // Misaligned target: bit 0 is cleared, bit 1 sets the sticky flag.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0203;
        step();
        cond_stage = 1'b0;
        check("mis_addr", imem_bus.imem_addr, 32'h202);
        check("mis_flag", {31'd0, misalign_err}, 32'd1);
        step();
        step();
        check("mis_ifpc", IF_ID_PC, 32'h206);
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);

        // Back-to-back redirects: the later target wins.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0300;
        step();
        HAZ_OUT = 32'h0000_0400;
        step();
        cond_stage = 1'b0;
        check("b2b_addr", imem_bus.imem_addr, 32'h400);
        check("b2b_valid0", {31'd0, IF_ID_valid}, 32'd0);
        step();
        check("b2b_pc", IF_ID_PC, 32'h400);
        check("b2b_ir", IF_ID_IR, 32'hA500_0400);
        check("b2b_taken", {16'd0, taken_cnt}, 32'd6);

        // PC wraps modulo 2^32.
        cond_stage = 1'b1; HAZ_OUT = 32'hFFFF_FFFC;
        step();
        cond_stage = 1'b0;
        step();
        check("wrap_ifpc", IF_ID_PC, 32'hFFFF_FFFC);
        check("wrap_npc", IF_ID_NPC, 32'd0);
        check("wrap_addr", imem_bus.imem_addr, 32'd0);

        // Reset asserted during a REDIRECT cycle.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0500;
        step();
        rst_n = 1'b0;
        #1;
        check("rr_flush", {31'd0, flush_id_ex}, 32'd0);
        step();
        rst_n = 1'b1; cond_stage = 1'b0;
        check("rr_addr", imem_bus.imem_addr, 32'd0);
        check("rr_taken", {16'd0, taken_cnt}, 32'd0);
        check("rr_misalign", {31'd0, misalign_err}, 32'd0);
        check("rr_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rr_ifpc", IF_ID_PC, 32'd0);
        step(); // BOOT edge
        check("rr_boot_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rr_boot_addr", imem_bus.imem_addr, 32'd0);
        step();
        check("rr_first_ir", IF_ID_IR, 32'h0050_0093);
        check("rr_first_valid", {31'd0, IF_ID_valid}, 32'd1);

        // Saturation: 65537 redirects leave the counter at 16'hFFFF.
        cond_stage = 1'b1; HAZ_OUT = 32'h0000_0008;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat_65534", {16'd0, taken_cnt}, 32'h0000_FFFE);
        step();
        check("sat_65535", {16'd0, taken_cnt}, 32'h0000_FFFF);
        step();
        step();
        cond_stage = 1'b0;
        check("sat_65537", {16'd0, taken_cnt}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_pc_redirect.md
# if_pc_redirect

Fetch-stage PC controller and IF/ID pipeline register. It owns the program counter and drives the instruction-memory address. It captures each fetched instruction into IF/ID. When the EX-stage branch/jump resolver signals a taken control transfer (`cond_stage`, target `HAZ_OUT`), it redirects fetch and squashes the wrong-path instructions in IF and ID. It sits directly downstream of that resolver, and its IF/ID outputs feed the decode stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000000: PC loaded on reset.
- `NOP_IR`, default 32'h00000013 (`addi x0,x0,0`): encoding injected as a bubble.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `cond_stage`, in, 1: taken control transfer resolved in EX this cycle.
- `HAZ_OUT`, in, 32: redirect target; valid when `cond_stage`=1.
- `stall`, in, 1: load-use hold from decode; freezes PC and IF/ID.
- `imem_addr`, out, 32: instruction-memory address, equal to the current PC.
- `imem_rdata`, in, 32: instruction word at `imem_addr`; combinational read, same cycle.
- `IF_ID_IR`, out, 32: registered instruction.
- `IF_ID_PC`, out, 32: registered PC of `IF_ID_IR`.
- `IF_ID_NPC`, out, 32: registered `IF_ID_PC`+4.
- `IF_ID_valid`, out, 1: 0 when `IF_ID_IR` is a bubble.
- `flush_id_ex`, out, 1: combinational; asserted when ID/EX must load a bubble at this edge.
- `misalign_err`, out, 1: sticky; set by a redirect to a non-word-aligned target.
- `taken_cnt`, out, 16: count of redirects; saturates at 16'hFFFF.

## Operation
- State machine with three states: BOOT, RUN, REDIRECT.
  - BOOT is the only state entered from reset. It lasts exactly one cycle, during which IF/ID is not loaded. It then goes to RUN.
  - RUN goes to REDIRECT on `cond_stage`=1. Otherwise it stays in RUN.
  - REDIRECT lasts exactly one cycle (the fetch of the target). It returns to RUN, or stays in REDIRECT if `cond_stage`=1 again.
- Reset (`rst_n`=0 sampled at an edge) sets the following, whatever the state or any operation in progress:
  - PC=`RESET_PC`, state=BOOT.
  - `IF_ID_IR`=`NOP_IR`, `IF_ID_PC`=0, `IF_ID_NPC`=0, `IF_ID_valid`=0.
  - `misalign_err`=0, `taken_cnt`=0.
  - `flush_id_ex`=0 while `rst_n`=0.
- Effective target is {`HAZ_OUT`[31:1],1'b0}: bit 0 is always cleared. If `HAZ_OUT`[1]=1, `misalign_err` is set; the redirect still happens to the bit-0-cleared address.
- Per-edge priority (first match wins):
  1. Reset.
  2. `cond_stage`=1:
     - PC ← effective target.
     - IF/ID ← bubble (`NOP_IR`, valid 0; `IF_ID_PC` and `IF_ID_NPC` hold).
     - `taken_cnt` +1, saturating.
  3. `stall`=1: PC and all IF/ID registers hold.
  4. State BOOT: PC holds; IF/ID holds the bubble.
  5. Otherwise (normal fetch):
     - `IF_ID_IR` ← `imem_rdata`, `IF_ID_PC` ← PC, `IF_ID_NPC` ← PC+4, `IF_ID_valid` ← 1.
     - PC ← PC+4.
- `flush_id_ex` = `rst_n` & `cond_stage`. The younger instruction in ID is squashed by the ID/EX owner.
- `cond_stage` with `stall` both 1: the redirect wins and the stall is ignored, because the stalled instruction is wrong-path.
- PC arithmetic is 32-bit modulo. 32'hFFFFFFFC+4 wraps to 0 with no error.

## Timing
- `imem_addr` equals PC combinationally; zero-latency fetch.
- Normal fetch: the instruction at PC appears on `IF_ID_IR` one edge later. Throughput is 1 per cycle.
- Redirect latency, with `cond_stage`=1 in cycle N:
  - Cycle N: `flush_id_ex`=1.
  - Edge N: PC=target, `IF_ID_valid`=0.
  - Edge N+1: `IF_ID_IR`=imem[target], `IF_ID_valid`=1.
  - Taken-branch penalty is exactly 2 bubbles: the IF and ID slots.
- First valid instruction: reset released before edge 0 → BOOT during cycle 0. imem[`RESET_PC`] is captured at edge 1.
- Back-to-back `cond_stage` in consecutive cycles: each one redirects, and the later target wins.

## Test plan
- Reset, then release with imem[0]=32'h00500093:
  - Cycle 0: `IF_ID_valid`=0.
  - After edge 1: `IF_ID_IR`=32'h00500093, `IF_ID_PC`=0, `IF_ID_NPC`=4.
  - After edge 2: `imem_addr`=8.
- Sequential fetch for 4 cycles → `IF_ID_PC` goes 0,4,8,12 with valid=1; `taken_cnt`=0.
- `cond_stage`=1, `HAZ_OUT`=32'h00000100 while PC=32'h10:
  - `flush_id_ex`=1 the same cycle.
  - Next cycle: `imem_addr`=32'h100, `IF_ID_valid`=0.
  - Following cycle: `IF_ID_PC`=32'h100, valid=1; `taken_cnt`=1.
- `stall`=1 for 3 cycles at PC=32'h20 → PC and `IF_ID_*` are unchanged. Then with `stall`=1 and `cond_stage`=1 (`HAZ_OUT`=32'h40) in the same cycle → PC=32'h40 on the next edge.
- `cond_stage`=1, `HAZ_OUT`=32'h00000203 → PC=32'h202 and `misalign_err`=1. The flag stays set until `rst_n`=0.
- Assert `rst_n`=0 during a REDIRECT cycle → next edge PC=`RESET_PC`, state BOOT, `taken_cnt`=0, `misalign_err`=0, `IF_ID_valid`=0. Also force 65537 redirects → `taken_cnt` holds at 16'hFFFF.
